// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and helpers for reg_file_mp.
// Reset values, per-index reset lookup and parity used by REGFILE_PARITY_EN.
package reg_file_pkg;

  localparam logic [7:0] REG2_RST = 8'h81;
  localparam logic [7:0] REG3_RST = 8'h20;

  function automatic logic [7:0] rst_val(input int idx);
    logic [7:0] v;
    v = 8'h00;
    case (idx)
      2:       v = REG2_RST;
      3:       v = REG3_RST;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Zero-extended inputs leave even parity unchanged.
  function automatic logic parity(input logic [255:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/reg_file_rd_stage.sv
// reg_file_rd_stage: one {valid, err, data} read pipeline register.
// Asynchronous active-low reset clears the in-flight result.
module reg_file_rd_stage #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              v_i,
  input  logic              e_i,
  input  logic [DATA_W-1:0] d_i,
  output logic              v_o,
  output logic              e_o,
  output logic [DATA_W-1:0] d_o
);

  logic              v_q;
  logic              e_q;
  logic [DATA_W-1:0] d_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v_q <= 1'b0;
      e_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_i;
      e_q <= e_i;
      d_q <= d_i;
    end
  end

  assign v_o = v_q;
  assign e_o = e_q;
  assign d_o = d_q;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file, one read + one write per cycle.
// Write-first bypass; REGFILE_PARITY_EN adds per-entry parity and ErrInj.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int EXP_N   = 4,
  parameter int RD_PIPE = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WrEn,
  input  logic [ADDR_W-1:0]       WrAddr,
  input  logic [DATA_W-1:0]       WrData,
  input  logic                    RdEn,
  input  logic [ADDR_W-1:0]       RdAddr,
`ifdef REGFILE_PARITY_EN
  input  logic                    ErrInj,
`endif
  output logic [DATA_W-1:0]       RdData,
  output logic                    RdData_Valid,
  output logic                    RdErr,
  output logic [EXP_N*DATA_W-1:0] RegOut
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_mem;
  logic              wr_ok;
  logic              rd_ok;
  logic              byp;
  logic              perr;

  assign wr_ok = WrEn && ({1'b0, WrAddr} < DEPTH_L);
  assign rd_ok = {1'b0, RdAddr} < DEPTH_L;
  assign byp   = wr_ok && (WrAddr == RdAddr);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= DATA_W'(rst_val(i));
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_ok && (WrAddr == ADDR_W'(i)))
          mem_q[i] <= WrData;
    end
  end

  always_comb begin
    rd_mem = '0;
    for (int i = 0; i < DEPTH; i++)
      if (RdAddr == ADDR_W'(i))
        rd_mem = mem_q[i];
  end

`ifdef REGFILE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             rd_par;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++)
        par_q[i] <= parity(256'(DATA_W'(rst_val(i))));
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_ok && (WrAddr == ADDR_W'(i)))
          par_q[i] <= parity(256'(WrData)) ^ ErrInj;
    end
  end

  always_comb begin
    rd_par = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (RdAddr == ADDR_W'(i))
        rd_par = par_q[i];
  end

  assign perr = rd_par ^ parity(256'(rd_mem));
`else
  assign perr = 1'b0;
`endif

  logic              cap_v_q, cap_v_d;
  logic              cap_e_q, cap_e_d;
  logic [DATA_W-1:0] cap_d_q, cap_d_d;

  // Bypass data is chosen here, so later writes cannot touch it.
  always_comb begin
    cap_v_d = RdEn;
    cap_e_d = 1'b0;
    cap_d_d = '0;
    if (RdEn) begin
      if (!rd_ok) begin
        cap_e_d = 1'b1;
      end else if (byp) begin
        cap_d_d = WrData;
      end else begin
        cap_d_d = rd_mem;
        cap_e_d = perr;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cap_v_q <= 1'b0;
      cap_e_q <= 1'b0;
      cap_d_q <= '0;
    end else begin
      cap_v_q <= cap_v_d;
      cap_e_q <= cap_e_d;
      cap_d_q <= cap_d_d;
    end
  end

  logic [RD_PIPE:0]  v_c;
  logic [RD_PIPE:0]  e_c;
  logic [DATA_W-1:0] d_c [RD_PIPE+1];

  assign v_c[0] = cap_v_q;
  assign e_c[0] = cap_e_q;
  assign d_c[0] = cap_d_q;

  for (genvar g = 0; g < RD_PIPE; g++) begin : g_pipe
    reg_file_rd_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .CLK(CLK),
      .RST(RST),
      .v_i(v_c[g]),
      .e_i(e_c[g]),
      .d_i(d_c[g]),
      .v_o(v_c[g+1]),
      .e_o(e_c[g+1]),
      .d_o(d_c[g+1])
    );
  end

  assign RdData_Valid = v_c[RD_PIPE];
  assign RdErr        = e_c[RD_PIPE];
  assign RdData       = d_c[RD_PIPE];

  for (genvar g = 0; g < EXP_N; g++) begin : g_exp
    assign RegOut[g*DATA_W +: DATA_W] = mem_q[g];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: table-driven bench with scoreboard queues for two
// instances of reg_file_mp (RD_PIPE=0 and RD_PIPE=1), DEPTH=12.
module tb_reg_file_mp;

  localparam int DEP = 12;

  typedef struct packed {
    logic       v;
    logic       e;
    logic [7:0] d;
  } res_t;

  typedef struct packed {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic       inj;
    res_t       x;
  } vec_t;

  logic        CLK;
  logic        RST;
  logic        WrEn;
  logic [3:0]  WrAddr;
  logic [7:0]  WrData;
  logic        RdEn;
  logic [3:0]  RdAddr;
  logic        ErrInj;
  logic [7:0]  d0, d1;
  logic        v0, v1, e0, e1;
  logic [31:0] ro0, ro1;

  int vectors;
  int miscompares;
  logic [7:0] model [DEP];
  res_t q0 [$];
  res_t q1 [$];
  vec_t tbl [19];
  res_t idle_r;

  reg_file_mp #(
    .DATA_W(8), .DEPTH(DEP), .ADDR_W(4), .EXP_N(4), .RD_PIPE(0)
  ) u_dut0 (
    .CLK(CLK), .RST(RST),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn(RdEn), .RdAddr(RdAddr),
`ifdef REGFILE_PARITY_EN
    .ErrInj(ErrInj),
`endif
    .RdData(d0), .RdData_Valid(v0), .RdErr(e0), .RegOut(ro0)
  );

  reg_file_mp #(
    .DATA_W(8), .DEPTH(DEP), .ADDR_W(4), .EXP_N(4), .RD_PIPE(1)
  ) u_dut1 (
    .CLK(CLK), .RST(RST),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn(RdEn), .RdAddr(RdAddr),
`ifdef REGFILE_PARITY_EN
    .ErrInj(ErrInj),
`endif
    .RdData(d1), .RdData_Valid(v1), .RdErr(e1), .RegOut(ro1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(logic we, logic [3:0] wa, logic [7:0] wd,
                              logic re, logic [3:0] ra, logic inj,
                              logic v, logic e, logic [7:0] d);
    vec_t t;
    t.we = we; t.wa = wa; t.wd = wd;
    t.re = re; t.ra = ra; t.inj = inj;
    t.x.v = v; t.x.e = e; t.x.d = d;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) model[i] = 8'h00;
    model[2] = 8'h81;
    model[3] = 8'h20;
  endtask

  task automatic pop_chk(input string nm, input int which);
    res_t r;
    if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got empty scoreboard expected entry", nm);
    end else if (which == 0) begin
      r = q0.pop_front();
      chk(nm, 32'({v0, e0, d0}), 32'(r));
    end else begin
      r = q1.pop_front();
      chk(nm, 32'({v1, e1, d1}), 32'(r));
    end
  endtask

  task automatic step(input vec_t t, input string nm);
    logic [31:0] exp_ro;
    WrEn   = t.we;
    WrAddr = t.wa;
    WrData = t.wd;
    RdEn   = t.re;
    RdAddr = t.ra;
    ErrInj = t.inj;
    q0.push_back(t.x);
    q1.push_back(t.x);
    @(posedge CLK);
    if (t.we && int'(t.wa) < DEP) model[int'(t.wa)] = t.wd;
    #1;
    pop_chk({nm, "/p0"}, 0);
    pop_chk({nm, "/p1"}, 1);
    exp_ro = {model[3], model[2], model[1], model[0]};
    chk({nm, "/regout0"}, ro0, exp_ro);
    chk({nm, "/regout1"}, ro1, exp_ro);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_r      = '0;
    model_reset();

    tbl[0]  = mk(0, 4'd0,  8'h00, 1, 4'd2,  0, 1, 0, 8'h81);
    tbl[1]  = mk(0, 4'd0,  8'h00, 1, 4'd3,  0, 1, 0, 8'h20);
    tbl[2]  = mk(0, 4'd0,  8'h00, 1, 4'd0,  0, 1, 0, 8'h00);
    tbl[3]  = mk(1, 4'd7,  8'h5A, 0, 4'd0,  0, 0, 0, 8'h00);
    tbl[4]  = mk(0, 4'd0,  8'h00, 1, 4'd7,  0, 1, 0, 8'h5A);
    tbl[5]  = mk(1, 4'd5,  8'h11, 0, 4'd0,  0, 0, 0, 8'h00);
    tbl[6]  = mk(1, 4'd5,  8'hC3, 1, 4'd5,  0, 1, 0, 8'hC3);
    tbl[7]  = mk(0, 4'd0,  8'h00, 1, 4'd5,  0, 1, 0, 8'hC3);
    tbl[8]  = mk(1, 4'd13, 8'hFF, 1, 4'd13, 0, 1, 1, 8'h00);
    tbl[9]  = mk(0, 4'd0,  8'h00, 1, 4'd13, 0, 1, 1, 8'h00);
    tbl[10] = mk(1, 4'd0,  8'hA5, 1, 4'd1,  0, 1, 0, 8'h00);
    tbl[11] = mk(0, 4'd0,  8'h00, 1, 4'd0,  0, 1, 0, 8'hA5);
    tbl[12] = mk(1, 4'd1,  8'h3C, 1, 4'd11, 0, 1, 0, 8'h00);
    tbl[13] = mk(1, 4'd11, 8'h77, 1, 4'd1,  0, 1, 0, 8'h3C);
    tbl[14] = mk(0, 4'd0,  8'h00, 1, 4'd11, 0, 1, 0, 8'h77);
    tbl[15] = mk(0, 4'd0,  8'h00, 1, 4'd12, 0, 1, 1, 8'h00);
    tbl[16] = mk(1, 4'd15, 8'hEE, 1, 4'd15, 0, 1, 1, 8'h00);
    tbl[17] = mk(1, 4'd2,  8'hB7, 1, 4'd2,  0, 1, 0, 8'hB7);
    tbl[18] = mk(0, 4'd0,  8'h00, 1, 4'd3,  0, 1, 0, 8'h20);

    RST = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0;
    RdEn = 1'b0; RdAddr = '0; ErrInj = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out0", 32'({v0, e0, d0}), 32'h0);
    chk("rst_out1", 32'({v1, e1, d1}), 32'h0);
    chk("rst_regout0", ro0, 32'h2081_0000);
    chk("rst_regout1", ro1, 32'h2081_0000);
    RST = 1'b1;
    q1.push_back(idle_r);

    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < DEP; i++)
      step(mk(0, 4'd0, 8'h00, 1, 4'(i), 0, 1, 0, model[i]),
           $sformatf("sweep%0d", i));

`ifdef REGFILE_PARITY_EN
    step(mk(1, 4'd4, 8'h0F, 0, 4'd0, 1, 0, 0, 8'h00), "par_inj_wr");
    step(mk(0, 4'd0, 8'h00, 1, 4'd4, 0, 1, 1, 8'h0F), "par_err_rd");
    step(mk(1, 4'd4, 8'h0F, 1, 4'd4, 1, 1, 0, 8'h0F), "par_byp");
    step(mk(0, 4'd0, 8'h00, 1, 4'd4, 0, 1, 1, 8'h0F), "par_err_rd2");
    step(mk(1, 4'd4, 8'h0F, 0, 4'd0, 0, 0, 0, 8'h00), "par_fix_wr");
    step(mk(0, 4'd0, 8'h00, 1, 4'd4, 0, 1, 0, 8'h0F), "par_ok_rd");
`endif

    step(mk(0, 4'd0, 8'h00, 1, 4'd0, 0, 1, 0, model[0]), "b2b_rd0");
    step(mk(0, 4'd0, 8'h00, 1, 4'd1, 0, 1, 0, model[1]), "b2b_rd1");
    WrEn = 1'b0; RdEn = 1'b1; RdAddr = 4'd2; ErrInj = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    chk("midrst_out0", 32'({v0, e0, d0}), 32'h0);
    chk("midrst_out1", 32'({v1, e1, d1}), 32'h0);
    chk("midrst_regout0", ro0, 32'h2081_0000);
    chk("midrst_regout1", ro1, 32'h2081_0000);
    @(posedge CLK);
    #1;
    chk("inrst_out0", 32'({v0, e0, d0}), 32'h0);
    chk("inrst_out1", 32'({v1, e1, d1}), 32'h0);
    RdEn = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    model_reset();
    q0.delete();
    q1.delete();
    q1.push_back(idle_r);
    for (int i = 0; i < 3; i++)
      step(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 0, 0, 8'h00),
           $sformatf("post_rst_idle%0d", i));
    step(mk(0, 4'd0, 8'h00, 1, 4'd2, 0, 1, 0, 8'h81), "post_rst_rd2");
    step(mk(0, 4'd0, 8'h00, 1, 4'd3, 0, 1, 0, 8'h20), "post_rst_rd3");
    step(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 0, 0, 8'h00), "flush");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised register file, successor to the fixed 8x8 system register file. It sits between the system controller and the ALU/UART/clock-divider configuration consumers. Unlike its predecessor, it accepts a read and a write in the same cycle, with write-first bypass. It also adds a configurable read pipeline, out-of-range address detection and a parametrised number of exported configuration registers.

## Interface
- DATA_W, 8, data width in bits
- DEPTH, 16, number of entries (2..256)
- ADDR_W, 4, address width; must satisfy 2^ADDR_W >= DEPTH
- EXP_N, 4, number of entries exported in parallel on RegOut (1..DEPTH)
- RD_PIPE, 0, extra read pipeline stages (0 or 1)

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock
- RST  in  1  asynchronous active-low reset
- WrEn  in  1  write strobe
- WrAddr  in  ADDR_W  write address
- WrData  in  DATA_W  write data
- RdEn  in  1  read strobe
- RdAddr  in  ADDR_W  read address
- RdData  out  DATA_W  read data, zero when RdData_Valid=0
- RdData_Valid  out  1  one-cycle pulse per accepted read
- RdErr  out  1  qualifies RdData_Valid: address out of range (or parity fault, see Configuration)
- RegOut  out  EXP_N*DATA_W  entries 0..EXP_N-1 concatenated, entry 0 in the LSBs
- ErrInj  in  1  present only with REGFILE_PARITY_EN: inverts the stored parity bit of the current write

## Operation
- Reset values:
  - entry 2 = 8'b100000_01 (prescale 32, even parity, parity enabled)
  - entry 3 = 8'h20 (TX divide ratio 32)
  - all other entries 0
  - RdData = 0, RdData_Valid = 0, RdErr = 0, read pipeline cleared
  - For DATA_W != 8, the reset constants are zero-extended or truncated.
- Write: with WrEn=1 and WrAddr < DEPTH, the entry is updated at the clock edge. With WrAddr >= DEPTH, the write is silently dropped and no state changes.
- Read: RdEn=1 captures the entry at RdAddr. With RdAddr >= DEPTH, the read returns RdData=0 and RdErr=1, still with a valid pulse.
- Simultaneous RdEn and WrEn:
  - Both are performed.
  - If RdAddr == WrAddr and the address is in range, the read returns WrData (write-first bypass).
  - With different addresses, the two operations are independent.
- Reads are fully pipelined: one read may be accepted every cycle, and results return in order.
- RegOut is driven combinationally from the storage array, so it reflects a write one cycle after the write strobe.
- No state machine beyond the read valid/data pipeline. The pipeline is a shift chain of {valid, err, data} of length 1+RD_PIPE.

## Timing
- RD_PIPE=0: RdEn sampled at edge N; RdData/RdData_Valid/RdErr valid after edge N for exactly one cycle.
- RD_PIPE=1: the same outputs appear after edge N+1.
- The bypass value is selected at acceptance, edge N. A write at edge N+1 does not alter an in-flight read.
- Reset asserted mid-read: in-flight reads are discarded and outputs go to zero asynchronously. No valid pulse appears after reset release for reads accepted before reset.
- The first access is permitted on the first edge after RST deasserts.

## Configuration
- REGFILE_PARITY_EN defined:
  - Each entry stores an extra even-parity bit, computed on write and initialised consistently at reset.
  - Reads recompute parity. A mismatch asserts RdErr with the true stored data on RdData.
  - A bypassed read never reports a parity error.
  - The ErrInj port exists.
- REGFILE_PARITY_EN undefined: no parity storage, no ErrInj port, and RdErr reflects only out-of-range addresses.

## Structure
- Shared package reg_file_pkg holds:
  - the reset-value constants (REG2_RST = 8'h81, REG3_RST = 8'h20)
  - a function returning the reset value per index
  - the parity function
- One sub-module, reg_file_rd_stage: a single parameterised {valid, err, data} register stage with async reset. It is instantiated RD_PIPE times after the capture stage.
- The storage array, write decode and bypass mux stay in the top module.

## Test plan
- Reset check: with EXP_N=4, RegOut = {8'h20, 8'h81, 8'h00, 8'h00} (entry 3 in the MSBs, entry 0 in the LSBs). A read of address 2 returns 8'h81 with RdErr=0.
- Write then read: write 0x5A to address 7, then read it. RdData=0x5A one cycle after RdEn (RD_PIPE=0) or two cycles after (RD_PIPE=1).
- Same-cycle bypass: addr 5 holds 0x11. WrEn and RdEn to addr 5 with WrData=0xC3 return 0xC3, and a subsequent read of addr 5 returns 0xC3.
- Out of range: with DEPTH=12, write 0xFF to addr 13, then read addr 13. The read gives RdData=0, RdErr=1, valid=1, and no entry changes.
- Back-to-back: reads of addrs 0..3 on four consecutive cycles produce four consecutive valid pulses in order. Assert RST during the third read; verify no further pulses and all outputs zero.
- With REGFILE_PARITY_EN: write 0x0F to addr 4 with ErrInj=1, then read addr 4. The read gives RdData=0x0F, RdErr=1.
